logic_unit_pipe: RTL and testbench

//  Parametrised, pipelined bitwise logic unit. It succeeds the fixed 16-bit OR gate.
//  It provides 8 selectable bitwise ops on WIDTH-bit operands and has an internal

---
 rtl/logic_unit_if.sv | 28 ++
 rtl/logic_unit_pipe.sv | 95 +++++++++
 tb/tb_logic_unit_pipe.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_if.sv
// Handshake/bus bundle for the pipelined bitwise logic unit.
// The master side drives operands and out_ready; the slave side is the unit.
interface logic_unit_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       in_op;
   logic             in_acc;
   logic             acc_clr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_zero;
   logic             out_ones;
   logic             out_parity;
   logic [WIDTH-1:0] acc_value;

   modport master (
      output in_valid, in_a, in_b, in_op, in_acc, acc_clr, out_ready,
      input  in_ready, out_valid, out_data, out_zero, out_ones, out_parity, acc_value
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, in_acc, acc_clr, out_ready,
      output in_ready, out_valid, out_data, out_zero, out_ones, out_parity, acc_value
   );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with accumulator, 1-cycle latency,
// valid/ready on both sides with full throughput.
module logic_unit_lane (
   input  logic       a,
   input  logic       b,
   input  logic [2:0] op,
   output logic       y
);
   always_comb begin
      y = a | b;
      case (op)
         3'd0: y = a | b;
         3'd1: y = a & b;
         3'd2: y = a ^ b;
         3'd3: y = ~(a | b);
         3'd4: y = ~(a & b);
         3'd5: y = ~(a ^ b);
         3'd6: y = a & ~b;
         3'd7: y = a;
         default: y = a | b;
      endcase
   end
endmodule

module logic_unit_pipe #(
   parameter int WIDTH = 16
) (
   input logic         clk,
   input logic         rst,
   logic_unit_if.slave bus
);
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_src;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             zero_q;
   logic             ones_q;
   logic             parity_q;
   logic             in_ready;
   logic             accept;

   // A clear in the same cycle as an accumulate beat makes the op see B=0.
   assign acc_src  = bus.acc_clr ? '0 : acc_q;
   assign b_eff    = bus.in_acc ? acc_src : bus.in_b;
   assign in_ready = ~valid_q | bus.out_ready;
   assign accept   = bus.in_valid & in_ready;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_lane
         logic_unit_lane u_lane (
            .a  (bus.in_a[i]),
            .b  (b_eff[i]),
            .op (bus.in_op),
            .y  (result[i])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         zero_q   <= 1'b0;
         ones_q   <= 1'b0;
         parity_q <= 1'b0;
         acc_q    <= '0;
      end else begin
         if (accept) begin
            valid_q  <= 1'b1;
            data_q   <= result;
            zero_q   <= (result == '0);
            ones_q   <= (result == '1);
            parity_q <= ^result;
         end else if (bus.out_ready) begin
            valid_q  <= 1'b0;
         end
         // Clear is independent of the handshake, so it also lands during a stall.
         if (accept && bus.in_acc)
            acc_q <= result;
         else if (bus.acc_clr)
            acc_q <= '0;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = valid_q;
   assign bus.out_data   = data_q;
   assign bus.out_zero   = zero_q;
   assign bus.out_ones   = ones_q;
   assign bus.out_parity = parity_q;
   assign bus.acc_value  = acc_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed scenarios plus random traffic checked
// against a cycle-level behavioural model and an in-order result scoreboard.
module tb_logic_unit_pipe;
   localparam int W = 16;
   localparam logic [W-1:0] ONES = '1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic_unit_if #(.WIDTH(W)) bus ();

   logic_unit_pipe #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic         m_valid;
   logic [W-1:0] m_data;
   logic [W-1:0] m_acc;
   logic         m_zero;
   logic         m_ones;
   logic         m_par;
   logic [W-1:0] sb_q[$];
   logic [W-1:0] del_q[$];

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] op_fn(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      case (op)
         3'd0: return a | b;
         3'd1: return a & b;
         3'd2: return a ^ b;
         3'd3: return ~(a | b);
         3'd4: return ~(a & b);
         3'd5: return ~(a ^ b);
         3'd6: return a & ~b;
         default: return a;
      endcase
   endfunction

   // One clock: check DUT against the model mid-cycle, then advance the model.
   task automatic cycle();
      logic         acc_now;
      logic [W-1:0] bsrc;
      logic [W-1:0] r;
      logic         n_valid;
      logic [W-1:0] n_data;
      logic [W-1:0] n_acc;
      logic         n_zero;
      logic         n_ones;
      logic         n_par;
      @(negedge clk);
      chk("in_ready", bus.in_ready, !m_valid || bus.out_ready);
      chk("out_valid", bus.out_valid, m_valid);
      chk("out_data", bus.out_data, m_data);
      chk("out_zero", bus.out_zero, m_zero);
      chk("out_ones", bus.out_ones, m_ones);
      chk("out_parity", bus.out_parity, m_par);
      chk("acc_value", bus.acc_value, m_acc);
      n_valid = m_valid; n_data = m_data; n_acc = m_acc;
      n_zero = m_zero; n_ones = m_ones; n_par = m_par;
      acc_now = bus.in_valid && (!m_valid || bus.out_ready);
      bsrc = bus.in_acc ? (bus.acc_clr ? '0 : m_acc) : bus.in_b;
      r = op_fn(bus.in_op, bus.in_a, bsrc);
      if (rst) begin
         n_valid = 0; n_data = '0; n_acc = '0; n_zero = 0; n_ones = 0; n_par = 0;
         sb_q.delete();
      end else begin
         if (m_valid && bus.out_ready) begin
            del_q.push_back(bus.out_data);
            if (sb_q.size() > 0) chk("scoreboard", bus.out_data, sb_q.pop_front());
         end
         if (acc_now) begin
            n_valid = 1; n_data = r;
            n_zero = (r == 0); n_ones = (r == ONES); n_par = $countones(r) % 2;
            sb_q.push_back(r);
         end else if (bus.out_ready) begin
            n_valid = 0;
         end
         if (acc_now && bus.in_acc) n_acc = r;
         else if (bus.acc_clr) n_acc = '0;
      end
      @(posedge clk);
      #1;
      m_valid = n_valid; m_data = n_data; m_acc = n_acc;
      m_zero = n_zero; m_ones = n_ones; m_par = n_par;
   endtask

   task automatic beat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic acc, input logic clr);
      bus.in_valid = 1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
      bus.in_acc = acc; bus.acc_clr = clr;
      cycle();
   endtask

   logic [W-1:0] sweep_exp[8];
   int           got_n;

   initial begin
      sweep_exp = '{16'hFFF0, 16'hF000, 16'h0FF0, 16'h000F,
                    16'h0FFF, 16'hF00F, 16'h00F0, 16'hF0F0};
      m_valid = 0; m_data = '0; m_acc = '0; m_zero = 0; m_ones = 0; m_par = 0;
      rst = 1;
      bus.in_valid = 1; bus.in_a = 16'h5A5A; bus.in_b = 16'h1234; bus.in_op = 0;
      bus.in_acc = 1; bus.acc_clr = 0; bus.out_ready = 1;

      // Reset held two cycles with a beat offered.
      @(posedge clk); #1;
      cycle();
      cycle();
      chk("rst_valid", bus.out_valid, 1'b0);
      chk("rst_data", bus.out_data, 16'h0000);
      chk("rst_flags", {bus.out_zero, bus.out_ones, bus.out_parity}, 3'b000);
      chk("rst_acc", bus.acc_value, 16'h0000);
      rst = 0;

      // Op sweep.
      bus.out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         beat(i[2:0], 16'hF0F0, 16'hFF00, 0, 0);
         chk("sweep", bus.out_data, sweep_exp[i]);
      end
      beat(3'd1, 16'h0000, 16'hFFFF, 0, 0);
      chk("flag_zero", bus.out_zero, 1'b1);
      beat(3'd0, 16'hFFFF, 16'h0000, 0, 0);
      chk("flag_ones", bus.out_ones, 1'b1);
      chk("flag_par", bus.out_parity, 1'b0);

      // Backpressure: beat 1 taken, then stall while beat 2 is offered.
      beat(3'd7, 16'h0001, 16'h0000, 0, 0);
      del_q.delete();
      bus.out_ready = 0;
      beat(3'd7, 16'h0002, 16'h0000, 0, 0);
      beat(3'd7, 16'h0002, 16'h0000, 0, 0);
      chk("bp_ready", bus.in_ready, 1'b0);
      chk("bp_hold", bus.out_data, 16'h0001);
      bus.out_ready = 1;
      beat(3'd7, 16'h0002, 16'h0000, 0, 0);
      beat(3'd7, 16'h0003, 16'h0000, 0, 0);
      beat(3'd7, 16'h0004, 16'h0000, 0, 0);
      bus.in_valid = 0;
      cycle();
      got_n = del_q.size();
      chk("bp_count", got_n[W-1:0], 16'd4);
      for (int i = 0; i < 4; i++)
         if (i < del_q.size()) chk("bp_order", del_q[i], W'(i + 1));

      // Accumulate OR chain.
      beat(3'd0, 16'h0001, 16'hFFFF, 1, 1);
      chk("acc1", bus.acc_value, 16'h0001);
      beat(3'd0, 16'h0010, 16'hFFFF, 1, 0);
      chk("acc2", bus.acc_value, 16'h0011);
      beat(3'd0, 16'h0100, 16'hFFFF, 1, 0);
      chk("acc3", bus.acc_value, 16'h0111);
      chk("acc_out", bus.out_data, 16'h0111);

      // Clear collision, then clear during a stall.
      beat(3'd0, 16'h00FF, 16'h0000, 1, 1);
      chk("acc_ff", bus.acc_value, 16'h00FF);
      beat(3'd2, 16'h1234, 16'hFFFF, 1, 1);
      chk("clr_out", bus.out_data, 16'h1234);
      chk("clr_acc", bus.acc_value, 16'h1234);
      bus.out_ready = 0;
      beat(3'd0, 16'h0007, 16'h0000, 1, 1);
      chk("stall_clr", bus.acc_value, 16'h0000);
      chk("stall_data", bus.out_data, 16'h1234);

      // Mid-stream reset with a stalled result.
      bus.out_ready = 1;
      beat(3'd0, 16'h00AA, 16'h0000, 1, 0);
      bus.out_ready = 0; bus.in_valid = 0; bus.acc_clr = 0;
      cycle();
      rst = 1;
      cycle();
      chk("mrst_valid", bus.out_valid, 1'b0);
      chk("mrst_acc", bus.acc_value, 16'h0000);
      rst = 0;
      bus.out_ready = 1;
      beat(3'd7, 16'h0005, 16'h0000, 0, 0);
      chk("resume_valid", bus.out_valid, 1'b1);
      chk("resume_data", bus.out_data, 16'h0005);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom % 64) == 0;
         bus.in_valid = ($urandom % 4) != 0;
         case ($urandom % 4)
            0: bus.in_a = '0;
            1: bus.in_a = ONES;
            default: bus.in_a = W'($urandom);
         endcase
         bus.in_b = W'($urandom);
         bus.in_op = 3'($urandom);
         bus.in_acc = ($urandom % 3) == 0;
         bus.acc_clr = ($urandom % 8) == 0;
         bus.out_ready = ($urandom % 3) != 0;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
